// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and the basis-change matrices between the
// FIPS-197 polynomial basis and the GF(((2^2)^2)^2) tower basis.
package aes_pkg;

  localparam int unsigned AES_NBYTES = 16;
  localparam logic [7:0]  AFFINE_C     = 8'h63;
  localparam logic [7:0]  INV_AFFINE_C = 8'h05;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} fsm_e;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (elaboration-time helper).
  function automatic byte_t aes_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Some non-zero r with r^2 + r = c in the AES field.
  function automatic byte_t aes_root(byte_t c);
    byte_t r;
    r = 8'h00;
    for (int i = 255; i >= 0; i--) begin
      if ((aes_mul(8'(i), 8'(i)) ^ 8'(i)) == c) r = 8'(i);
    end
    return r;
  endfunction

  // Column k is the AES image of tower basis element v^k[2] * u^k[1] * alpha^k[0],
  // with alpha^2+alpha+1=0, u^2+u+alpha=0, v^2+v+alpha*u=0.
  function automatic logic [7:0][7:0] iso_to_aes_cols();
    byte_t a;
    byte_t u;
    byte_t v;
    logic [7:0][7:0] m;
    a = aes_root(8'h01);
    u = aes_root(a);
    v = aes_root(aes_mul(a, u));
    for (int k = 0; k < 8; k++) begin
      m[k] = 8'h01;
      if (k[0]) m[k] = aes_mul(m[k], a);
      if (k[1]) m[k] = aes_mul(m[k], u);
      if (k[2]) m[k] = aes_mul(m[k], v);
    end
    return m;
  endfunction

  function automatic byte_t iso_map(logic [7:0][7:0] m, byte_t x);
    byte_t y;
    y = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (x[k]) y = y ^ m[k];
    end
    return y;
  endfunction

  // Inverse basis change found by locating the preimage of each AES unit vector.
  function automatic logic [7:0][7:0] iso_from_aes_cols();
    logic [7:0][7:0] f;
    logic [7:0][7:0] m;
    byte_t y;
    f = iso_to_aes_cols();
    m = '0;
    for (int c = 0; c < 256; c++) begin
      y = iso_map(f, 8'(c));
      for (int j = 0; j < 8; j++) begin
        if (y == (8'h01 << j)) m[j] = 8'(c);
      end
    end
    return m;
  endfunction

  function automatic byte_t rotl8(byte_t b, int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic byte_t fwd_affine(byte_t b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFFINE_C;
  endfunction

  function automatic byte_t inv_affine(byte_t s);
    return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ INV_AFFINE_C;
  endfunction

  localparam logic [7:0][7:0] ISO_TO_AES   = iso_to_aes_cols();
  localparam logic [7:0][7:0] ISO_FROM_AES = iso_from_aes_cols();

endpackage

// File: rtl/gf_sbox_8.sv
// Combinational AES S-box / inverse S-box: multiplicative inverse computed in the
// GF(((2^2)^2)^2) tower, wrapped by basis changes and the (inverse) affine map.
module gf_sbox_8
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte_c
);

  function automatic logic [1:0] gf4_mul(logic [1:0] a, logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf4_sq(logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  // Multiply by alpha.
  function automatic logic [1:0] gf4_scl(logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [3:0] gf16_mul(logic [3:0] a, logic [3:0] b);
    logic [1:0] p;
    p = gf4_mul(a[3:2], b[3:2]);
    return {p ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
            gf4_scl(p) ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  function automatic logic [3:0] gf16_sq(logic [3:0] a);
    logic [1:0] s;
    s = gf4_sq(a[3:2]);
    return {s, gf4_scl(s) ^ gf4_sq(a[1:0])};
  endfunction

  // Multiply by lambda = alpha*u, the constant of the outer field polynomial.
  function automatic logic [3:0] gf16_scl(logic [3:0] a);
    return {gf4_scl(a[3:2] ^ a[1:0]), gf4_scl(gf4_scl(a[3:2]))};
  endfunction

  function automatic logic [3:0] gf16_inv(logic [3:0] a);
    logic [1:0] d;
    logic [1:0] di;
    d  = gf4_scl(gf4_sq(a[3:2])) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
    di = gf4_sq(d);
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction

  // (h*v + l)^-1 = (h*v + (h+l)) / (lambda*h^2 + h*l + l^2); zero maps to zero.
  function automatic logic [7:0] gf256_inv(logic [7:0] a);
    logic [3:0] d;
    logic [3:0] di;
    d  = gf16_scl(gf16_sq(a[7:4])) ^ gf16_mul(a[7:4], a[3:0]) ^ gf16_sq(a[3:0]);
    di = gf16_inv(d);
    return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
  endfunction

  logic [7:0] w_pre;
  logic [7:0] w_cin;
  logic [7:0] w_cout;
  logic [7:0] w_post;

  always_comb begin
    w_pre    = i_inv ? inv_affine(i_byte) : i_byte;
    w_cin    = iso_map(ISO_FROM_AES, w_pre);
    w_cout   = gf256_inv(w_cin);
    w_post   = iso_map(ISO_TO_AES, w_cout);
    o_byte_c = i_inv ? w_post : fwd_affine(w_post);
  end

endmodule

// File: rtl/aes_subbytes_seq.sv
// Byte-serial SubBytes/InvSubBytes sequencer: feeds one byte per cycle through a
// shared S-box, optionally pipelined, and reassembles the 128-bit result.
module aes_subbytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 1,
  parameter int unsigned NBYTES   = AES_NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_state,
  input  logic         i_in_inv,
  input  logic         i_flush,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_state,
  output logic         o_busy
);

  localparam int unsigned      CNT_W = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBYTES - 1);

  fsm_e             r_state;
  fsm_e             w_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  state_t           r_word;
  logic             r_inv;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             r_retire_done;
  state_t           r_out_state;

  logic   w_accept;
  logic   w_issue_vld;
  byte_t  w_issue_byte;
  byte_t  w_sbox_byte;
  logic   w_tail_vld;
  byte_t  w_tail_byte;

  assign w_accept     = (r_state == IDLE) && i_in_valid && !i_flush;
  assign w_issue_vld  = (r_state == FEED);
  assign w_issue_byte = r_word[{r_issue_cnt, 3'b000} +: 8];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = FEED;
      FEED:    if (r_issue_cnt == LAST) w_next = DRAIN;
      DRAIN:   if (r_retire_done) w_next = DONE;
      DONE:    if (i_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_flush) w_next = IDLE;
  end

  // Handshake outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
    end
  end

  gf_sbox_8 u_sbox (
    .i_byte   (w_issue_byte),
    .i_inv    (r_inv),
    .o_byte_c (w_sbox_byte)
  );

  generate
    if (SBOX_LAT == 0) begin : g_nopipe
      assign w_tail_vld  = w_issue_vld;
      assign w_tail_byte = w_sbox_byte;
    end else begin : g_pipe
      logic [SBOX_LAT-1:0] r_pipe_vld;
      byte_t               r_pipe_data [SBOX_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipe_vld <= '0;
          for (int i = 0; i < int'(SBOX_LAT); i++) r_pipe_data[i] <= 8'h00;
        end else if (i_flush) begin
          r_pipe_vld <= '0;
        end else begin
          r_pipe_vld[0]  <= w_issue_vld;
          r_pipe_data[0] <= w_sbox_byte;
          for (int i = 1; i < int'(SBOX_LAT); i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
          end
        end
      end

      assign w_tail_vld  = r_pipe_vld[SBOX_LAT-1];
      assign w_tail_byte = r_pipe_data[SBOX_LAT-1];
    end
  endgenerate

  // Input capture, issue/retire counters and result assembly; counters stop at LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word        <= '0;
      r_inv         <= 1'b0;
      r_issue_cnt   <= '0;
      r_retire_cnt  <= '0;
      r_retire_done <= 1'b0;
      r_out_state   <= '0;
    end else if (i_flush) begin
      r_issue_cnt   <= '0;
      r_retire_cnt  <= '0;
      r_retire_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word        <= i_in_state;
        r_inv         <= i_in_inv;
        r_issue_cnt   <= '0;
        r_retire_cnt  <= '0;
        r_retire_done <= 1'b0;
      end else if (w_issue_vld && (r_issue_cnt != LAST)) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_tail_vld) begin
        r_out_state[{r_retire_cnt, 3'b000} +: 8] <= w_tail_byte;
        if (r_retire_cnt == LAST) r_retire_done <= 1'b1;
        else                      r_retire_cnt  <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_out_state = r_out_state;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq: known-answer vectors, multi-cycle corner
// sequences and random words against a field-arithmetic reference model.
module tb_aes_subbytes_seq;

  localparam int unsigned LAT = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
  } vec_t;
  vec_t vec [6];

  aes_subbytes_seq #(.SBOX_LAT(LAT), .NBYTES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_state  (in_state),
    .i_in_inv    (in_inv),
    .i_flush     (flush),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_state (out_state),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Carry-less product then reduction by the AES polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] r;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = s[8*i +: 8];
      r[8*i +: 8] = inv ? isb[b] : sb[b];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One word through the block; inputs are scrambled and in_valid kept high while busy.
  task automatic send(input string name, input logic [127:0] st, input logic inv,
                      input logic [127:0] exp, input int hold);
    int           n;
    logic [127:0] cap;
    logic         ok;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({name, " in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_state = st;
    in_inv   = inv;
    @(negedge clk);
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = ~inv;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk({name, " latency"}, 128'(n), 128'(17 + LAT));
    chk({name, " result"}, out_state, exp);
    cap = out_state;
    ok  = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || !busy || out_state !== cap) ok = 1'b0;
    end
    if (hold > 0) chk({name, " hold stable"}, 128'(ok), 128'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " release"}, {125'd0, in_ready, out_valid, busy}, 128'b100);
  endtask

  initial begin
    logic [127:0] w;
    logic         r_inv_sel;
    logic         seen;
    logic [7:0]   inv_t;

    for (int x = 0; x < 256; x++) begin
      inv_t = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv_t = 8'(y);
      sb[x] = affine(inv_t);
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

    vec[0] = '{128'h0, 1'b0, {16{8'h63}}};
    vec[1] = '{128'h0F0E0D0C0B0A09080706050403020100, 1'b0,
               128'h76ABD7FE2B670130C56F6BF27B777C63};
    vec[2] = '{128'h76ABD7FE2B670130C56F6BF27B777C63, 1'b1,
               128'h0F0E0D0C0B0A09080706050403020100};
    vec[3] = '{{16{8'h53}}, 1'b0, {16{8'hED}}};
    vec[4] = '{{16{8'hED}}, 1'b1, {16{8'h53}}};
    vec[5] = '{128'h0, 1'b1, {16{8'h52}}};

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready",  128'(in_ready),  128'(1));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset busy",      128'(busy),      128'(0));
    chk("reset out_state", out_state,       128'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      send($sformatf("vec%0d", i), vec[i].st, vec[i].inv, vec[i].exp, 0);

    w = {$urandom, $urandom, $urandom, $urandom};
    send("hold20", w, 1'b0, model(w, 1'b0), 20);

    // Flush while byte 7 is being issued.
    in_valid = 1'b1; in_state = {$urandom, $urandom, $urandom, $urandom}; in_inv = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("flush busy before", 128'(busy), 128'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush idle", {126'd0, in_ready, busy}, 128'b10);
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("flush no out_valid", 128'(seen), 128'(0));
    w = {$urandom, $urandom, $urandom, $urandom};
    send("after flush", w, 1'b1, model(w, 1'b1), 0);

    // Flush beats a simultaneous in_valid in IDLE.
    in_valid = 1'b1; flush = 1'b1; in_state = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush vs accept", {126'd0, in_ready, busy}, 128'b10);

    // Asynchronous reset while draining the pipe.
    in_valid = 1'b1; in_state = {$urandom, $urandom, $urandom, $urandom}; in_inv = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("drain busy", {126'd0, busy, out_valid}, 128'b10);
    rst = 1'b1;
    #1;
    chk("async rst flags", {125'd0, in_ready, out_valid, busy}, 128'b100);
    chk("async rst out_state", out_state, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      send($sformatf("post-rst%0d", i), w, 1'(i), model(w, 1'(i)), 0);
    end

    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      r_inv_sel = 1'($urandom_range(0, 1));
      send($sformatf("rand%0d", i), w, r_inv_sel, model(w, r_inv_sel),
           int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
